// File: rtl/paddle_position_controller.sv
// Paddle position controller: turns per-edge count pulses from two quadrature decoders into clamped paddle positions.
// Optional macro PADDLE_ACCEL_EN adds a fast-turn double step per side.
module paddle_position_controller #(
    parameter int POS_W           = 5,
    parameter int POS_MAX         = 27,
    parameter int CENTER          = 13,
    parameter int EDGES_PER_CLICK = 4,
    parameter int RECENTER_DIV    = 50000,
    parameter int ACCEL_WINDOW    = 250000
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             CE_L,
    input  logic             DIR_L,
    input  logic             CE_R,
    input  logic             DIR_R,
    input  logic             FREEZE,
    input  logic             RECENTER,
    output logic [POS_W-1:0] POS_L,
    output logic [POS_W-1:0] POS_R,
    output logic             MOVED_L,
    output logic             MOVED_R,
    output logic             BUSY
);

    localparam int SUB_W = $clog2(EDGES_PER_CLICK);
    localparam int PRE_W = (RECENTER_DIV > 1) ? $clog2(RECENTER_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(EDGES_PER_CLICK - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RECENTER_DIV - 1);
    localparam logic [POS_W-1:0] CENTER_P = POS_W'(CENTER);

    if (CENTER > POS_MAX || EDGES_PER_CLICK < 2 || RECENTER_DIV < 1 || ACCEL_WINDOW < 1) begin : g_param_check
        $error("paddle_position_controller: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_TRACK,
        ST_FROZEN,
        ST_RECENTER
    } state_e;

    typedef struct packed {
        logic [SUB_W-1:0] sub;
        logic             up;
        logic             dn;
    } click_t;

    // Advance one sub-click counter; a wrap in either direction yields a click.
    function automatic click_t sub_step(input logic [SUB_W-1:0] sub, input logic ce, input logic dir);
        click_t r;
        r.sub = sub;
        r.up  = 1'b0;
        r.dn  = 1'b0;
        if (ce) begin
            if (dir) begin
                if (sub == SUB_LAST) begin
                    r.sub = '0;
                    r.up  = 1'b1;
                end else begin
                    r.sub = sub + 1'b1;
                end
            end else begin
                if (sub == '0) begin
                    r.sub = SUB_LAST;
                    r.dn  = 1'b1;
                end else begin
                    r.sub = sub - 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos, input logic up,
                                                  input logic dn, input logic big);
        int p;
        p = int'(pos);
        if (up) begin
            p = p + (big ? 2 : 1);
        end else if (dn) begin
            p = p - (big ? 2 : 1);
        end
        if (p > POS_MAX) p = POS_MAX;
        if (p < 0) p = 0;
        return POS_W'(p);
    endfunction

    function automatic logic [POS_W-1:0] toward_center(input logic [POS_W-1:0] pos);
        if (pos > CENTER_P) return pos - 1'b1;
        if (pos < CENTER_P) return pos + 1'b1;
        return pos;
    endfunction

    state_e           state_q, state_d;
    logic             ce_l_q, dir_l_q, ce_r_q, dir_r_q;
    logic [SUB_W-1:0] sub_l_q, sub_l_d, sub_r_q, sub_r_d;
    logic [POS_W-1:0] pos_l_q, pos_l_d, pos_r_q, pos_r_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             moved_l_q, moved_r_q;
    click_t           click_l, click_r;
    logic             big_l, big_r;
    logic             fire_l, fire_r;

`ifdef PADDLE_ACCEL_EN
    localparam int ACC_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [ACC_W-1:0] ACC_WIN_P = ACC_W'(ACCEL_WINDOW);

    logic [ACC_W-1:0] ivl_l_q, ivl_l_d, ivl_r_q, ivl_r_d;
    logic             last_dir_l_q, last_dir_l_d, last_dir_r_q, last_dir_r_d;

    // Interval since the last click saturates at the window; a click restarts it.
    always_comb begin
        ivl_l_d      = (ivl_l_q == ACC_WIN_P) ? ivl_l_q : ivl_l_q + 1'b1;
        ivl_r_d      = (ivl_r_q == ACC_WIN_P) ? ivl_r_q : ivl_r_q + 1'b1;
        last_dir_l_d = last_dir_l_q;
        last_dir_r_d = last_dir_r_q;
        if (fire_l) begin
            ivl_l_d      = '0;
            last_dir_l_d = dir_l_q;
        end
        if (fire_r) begin
            ivl_r_d      = '0;
            last_dir_r_d = dir_r_q;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            ivl_l_q      <= ACC_WIN_P;
            ivl_r_q      <= ACC_WIN_P;
            last_dir_l_q <= 1'b1;
            last_dir_r_q <= 1'b1;
        end else begin
            ivl_l_q      <= ivl_l_d;
            ivl_r_q      <= ivl_r_d;
            last_dir_l_q <= last_dir_l_d;
            last_dir_r_q <= last_dir_r_d;
        end
    end

    assign big_l = (dir_l_q == last_dir_l_q) && (ivl_l_q < ACC_WIN_P);
    assign big_r = (dir_r_q == last_dir_r_q) && (ivl_r_q < ACC_WIN_P);
`else
    assign big_l = 1'b0;
    assign big_r = 1'b0;
`endif

    assign click_l = sub_step(sub_l_q, ce_l_q, dir_l_q);
    assign click_r = sub_step(sub_r_q, ce_r_q, dir_r_q);
    assign fire_l  = (state_q == ST_TRACK) && (click_l.up || click_l.dn);
    assign fire_r  = (state_q == ST_TRACK) && (click_r.up || click_r.dn);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d = state_q;
        sub_l_d = sub_l_q;
        sub_r_d = sub_r_q;
        pos_l_d = pos_l_q;
        pos_r_d = pos_r_q;
        pre_d   = '0;

        unique case (state_q)
            ST_TRACK: begin
                sub_l_d = click_l.sub;
                sub_r_d = click_r.sub;
                pos_l_d = pos_step(pos_l_q, click_l.up, click_l.dn, big_l);
                pos_r_d = pos_step(pos_r_q, click_r.up, click_r.dn, big_r);
                if (RECENTER) begin
                    state_d = ST_RECENTER;
                    sub_l_d = '0;
                    sub_r_d = '0;
                end else if (FREEZE) begin
                    state_d = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                sub_l_d = '0;
                sub_r_d = '0;
                if (RECENTER) begin
                    state_d = ST_RECENTER;
                end else if (!FREEZE) begin
                    state_d = ST_TRACK;
                end
            end
            ST_RECENTER: begin
                sub_l_d = '0;
                sub_r_d = '0;
                if (pos_l_q == CENTER_P && pos_r_q == CENTER_P) begin
                    state_d = FREEZE ? ST_FROZEN : ST_TRACK;
                end else if (pre_q == PRE_LAST) begin
                    pos_l_d = toward_center(pos_l_q);
                    pos_r_d = toward_center(pos_r_q);
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = ST_TRACK;
        endcase
    end

    // Edges are captured one cycle ahead of the click logic; captures are refused unless tracking.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_TRACK;
            ce_l_q    <= 1'b0;
            dir_l_q   <= 1'b0;
            ce_r_q    <= 1'b0;
            dir_r_q   <= 1'b0;
            sub_l_q   <= '0;
            sub_r_q   <= '0;
            pos_l_q   <= CENTER_P;
            pos_r_q   <= CENTER_P;
            pre_q     <= '0;
            moved_l_q <= 1'b0;
            moved_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ce_l_q    <= CE_L && (state_q == ST_TRACK) && !RECENTER;
            dir_l_q   <= DIR_L;
            ce_r_q    <= CE_R && (state_q == ST_TRACK) && !RECENTER;
            dir_r_q   <= DIR_R;
            sub_l_q   <= sub_l_d;
            sub_r_q   <= sub_r_d;
            pos_l_q   <= pos_l_d;
            pos_r_q   <= pos_r_d;
            pre_q     <= pre_d;
            moved_l_q <= (pos_l_d != pos_l_q);
            moved_r_q <= (pos_r_d != pos_r_q);
        end
    end

    assign POS_L   = pos_l_q;
    assign POS_R   = pos_r_q;
    assign MOVED_L = moved_l_q;
    assign MOVED_R = moved_r_q;
    assign BUSY    = (state_q == ST_RECENTER);

endmodule

// File: tb/tb_paddle_position_controller.sv
// Directed bench for paddle_position_controller (RECENTER_DIV=4, ACCEL_WINDOW=8 for short runs).
module tb_paddle_position_controller;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic       CE_L, DIR_L, CE_R, DIR_R, FREEZE, RECENTER;
    logic [4:0] POS_L, POS_R;
    logic       MOVED_L, MOVED_R, BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    paddle_position_controller #(
        .POS_W          (5),
        .POS_MAX        (27),
        .CENTER         (13),
        .EDGES_PER_CLICK(4),
        .RECENTER_DIV   (4),
        .ACCEL_WINDOW   (8)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .CE_L    (CE_L),
        .DIR_L   (DIR_L),
        .CE_R    (CE_R),
        .DIR_R   (DIR_R),
        .FREEZE  (FREEZE),
        .RECENTER(RECENTER),
        .POS_L   (POS_L),
        .POS_R   (POS_R),
        .MOVED_L (MOVED_L),
        .MOVED_R (MOVED_R),
        .BUSY    (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic edge_l(input logic dir);
        CE_L  = 1'b1;
        DIR_L = dir;
        tick();
        CE_L  = 1'b0;
    endtask

    task automatic edge_r(input logic dir);
        CE_R  = 1'b1;
        DIR_R = dir;
        tick();
        CE_R  = 1'b0;
    endtask

    task automatic click_l(input logic dir, input int gap);
        repeat (4) edge_l(dir);
        repeat (gap) tick();
    endtask

    task automatic click_r(input logic dir, input int gap);
        repeat (4) edge_r(dir);
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        RESET = 1'b1; CE_L = 1'b0; DIR_L = 1'b0; CE_R = 1'b0; DIR_R = 1'b0;
        FREEZE = 1'b0; RECENTER = 1'b0;
        tick();
        check("rst_pos_l", POS_L, 13);
        check("rst_pos_r", POS_R, 13);
        check("rst_moved_l", MOVED_L, 0);
        check("rst_moved_r", MOVED_R, 0);
        check("rst_busy", BUSY, 0);
        RESET = 1'b0;
        tick();

        // Four up edges make one click, visible one edge after the last edge is sampled.
        repeat (4) edge_l(1'b1);
        check("t1_pos_l_before", POS_L, 13);
        tick();
        check("t1_pos_l", POS_L, 14);
        check("t1_moved_l", MOVED_L, 1);
        check("t1_pos_r", POS_R, 13);
        check("t1_moved_r", MOVED_R, 0);
        tick();
        check("t1_moved_l_drop", MOVED_L, 0);
        check("t1_pos_l_hold", POS_L, 14);

        // First down edge wraps 0->3 and clicks at once; the next two do not.
        do_reset();
        edge_r(1'b0);
        check("t2_pos_r_before", POS_R, 13);
        tick();
        check("t2_pos_r", POS_R, 12);
        check("t2_moved_r", MOVED_R, 1);
        edge_r(1'b0);
        edge_r(1'b0);
        tick();
        check("t2_pos_r_hold", POS_R, 12);
        check("t2_moved_r_drop", MOVED_R, 0);
        check("t2_pos_l", POS_L, 13);

        // Climb to the top, then clamp.
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            click_l(1'b1, 10);
            check($sformatf("t3_climb_%0d", i), POS_L, 13 + i);
        end
        for (int i = 0; i < 8; i++) begin
            edge_l(1'b1);
            check($sformatf("t3_clamp_moved_%0d", i), MOVED_L, 0);
        end
        tick();
        check("t3_clamp_moved_last", MOVED_L, 0);
        tick();
        check("t3_clamp_pos", POS_L, 27);
        repeat (4) edge_l(1'b0);
        tick();
        check("t3_down_pos", POS_L, 26);

        // Freeze ignores edges and clears the sub-counter.
        do_reset();
        FREEZE = 1'b1;
        tick();
        check("t4_busy", BUSY, 0);
        repeat (8) edge_l(1'b1);
        tick();
        check("t4_frozen_pos", POS_L, 13);
        check("t4_frozen_moved", MOVED_L, 0);
        FREEZE = 1'b0;
        tick();
        repeat (4) edge_l(1'b1);
        tick();
        check("t4_thaw_pos", POS_L, 14);

        // Recentering from 16/11 with steps every 4 cycles; edges held high throughout.
        do_reset();
        repeat (3) click_l(1'b1, 10);
        repeat (2) click_r(1'b0, 10);
        check("t5_setup_l", POS_L, 16);
        check("t5_setup_r", POS_R, 11);
        RECENTER = 1'b1;
        tick();
        RECENTER = 1'b0;
        check("t5_busy_rise", BUSY, 1);
        CE_L = 1'b1;
        DIR_L = 1'b1;
        repeat (3) tick();
        check("t5_k3_l", POS_L, 16);
        check("t5_k3_r", POS_R, 11);
        tick();
        check("t5_k4_l", POS_L, 15);
        check("t5_k4_r", POS_R, 12);
        check("t5_k4_moved_l", MOVED_L, 1);
        check("t5_k4_moved_r", MOVED_R, 1);
        repeat (4) tick();
        check("t5_k8_l", POS_L, 14);
        check("t5_k8_r", POS_R, 13);
        check("t5_k8_moved_r", MOVED_R, 1);
        tick();
        check("t5_k9_moved_l", MOVED_L, 0);
        repeat (3) tick();
        check("t5_k12_l", POS_L, 13);
        check("t5_k12_moved_l", MOVED_L, 1);
        check("t5_k12_moved_r", MOVED_R, 0);
        check("t5_k12_busy", BUSY, 1);
        tick();
        check("t5_k13_busy", BUSY, 0);
        check("t5_k13_moved_l", MOVED_L, 0);
        CE_L = 1'b0;
        repeat (3) tick();
        check("t5_ce_ignored", POS_L, 13);

        // Asynchronous reset in the middle of a recenter.
        click_l(1'b1, 10);
        click_r(1'b0, 10);
        RECENTER = 1'b1;
        tick();
        RECENTER = 1'b0;
        tick();
        check("t6_busy", BUSY, 1);
        check("t6_pos_l_pre", POS_L, 14);
        #2;
        RESET = 1'b1;
        #1;
        check("t6_async_l", POS_L, 13);
        check("t6_async_r", POS_R, 12 + 1);
        check("t6_async_busy", BUSY, 0);
        tick();
        RESET = 1'b0;
        tick();

        // Two back-to-back up clicks.
        repeat (2) click_l(1'b1, 0);
        repeat (2) tick();
`ifdef PADDLE_ACCEL_EN
        check("t7_fast_turn", POS_L, 16);
`else
        check("t7_fast_turn", POS_L, 15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
